// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE0  = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    // Number of downstream reset stages
    localparam int unsigned NUM_STAGES = 2;

    // Largest of four values, used to size the shared cycle counter
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Active-low stage resets for a given state: bit 0 releases first
    function automatic logic [NUM_STAGES-1:0] stage_rst_n(input seq_state_e st);
        case (st)
            ST_RELEASE0: return 2'b01;
            ST_RUN:      return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the refclk domain.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Capture the lock pin through two flops; both clear to 0 on reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor and two-stage downstream reset sequencer.
// Optional feature: define PLL_SEQ_LOSS_COUNT_EN to add the lock_loss_cnt output,
// a saturating count of lock losses after release (cleared only by rst_n).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned STAGE_GAP_CYCLES    = 8,
    localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    input  logic                  clear_fault,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  ready,
    output logic                  fault,
    output logic [RTY_W-1:0]      retry_cnt
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]            lock_loss_cnt
`endif
);

    localparam int unsigned CNT_MAXV = max4(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                            LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES);
    localparam int unsigned CNT_W = (CNT_MAXV > 1) ? $clog2(CNT_MAXV) : 1;

    // Terminal counts: each state is occupied for exactly N cycles
    localparam logic [CNT_W-1:0] RST_TC = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_TC  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    logic             locked_s;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    pll_lock_sync u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .async_i(pll_locked),
        .sync_o (locked_s)
    );

    // Next-state, counter and retry logic; loss of lock outranks soft reset
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_TC) state_d = ST_WAIT_LOCK;
                else                 state_d = ST_RESET_PLL;
            end
            ST_WAIT_LOCK: begin
                if (soft_reset_req) begin
                    state_d = ST_RESET_PLL;
                end else if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_TC) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_RESET_PLL;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!locked_s)            state_d = ST_WAIT_LOCK;
                else if (soft_reset_req)  state_d = ST_RESET_PLL;
                else if (cnt_q == STB_TC) state_d = ST_RELEASE0;
                else                      state_d = ST_STABLE;
            end
            ST_RELEASE0: begin
                if (!locked_s)            state_d = ST_RESET_PLL;
                else if (soft_reset_req)  state_d = ST_RESET_PLL;
                else if (cnt_q == GAP_TC) state_d = ST_RUN;
                else                      state_d = ST_RELEASE0;
            end
            ST_RUN: begin
                if (!locked_s)           state_d = ST_RESET_PLL;
                else if (soft_reset_req) state_d = ST_RESET_PLL;
                else                     state_d = ST_RUN;
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_d = ST_RESET_PLL;
                    retry_d = {RTY_W{1'b0}};
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        // Any state change restarts the cycle counter
        if (state_d != state_q) cnt_d = {CNT_W{1'b0}};
        else                    cnt_d = cnt_d;

        // A successful bring-up forgets earlier retries
        if (state_d == ST_RUN) retry_d = {RTY_W{1'b0}};
        else                   retry_d = retry_d;
    end

    // State registers and outputs decoded from the next state
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= {CNT_W{1'b0}};
            retry_q     <= {RTY_W{1'b0}};
            pll_rst     <= 1'b1;
            rst_stage_n <= {NUM_STAGES{1'b0}};
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst     <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
            rst_stage_n <= stage_rst_n(state_d);
            ready       <= (state_d == ST_RUN);
            fault       <= (state_d == ST_FAULT);
        end
    end

    assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_q;

    // Saturating count of lock losses after the first stage was released
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_q <= 8'd0;
        end else if (((state_q == ST_RELEASE0) || (state_q == ST_RUN)) && !locked_s
                     && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end else begin
            loss_q <= loss_q;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with reduced cycle parameters.
module tb_pll_reset_sequencer;

    localparam int P = 4;   // reset pulse
    localparam int L = 16;  // stable cycles
    localparam int T = 64;  // lock timeout
    localparam int R = 2;   // max retries
    localparam int G = 4;   // stage gap
    localparam int BUDGET = 500;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       clear_fault;
    logic       pll_rst;
    logic [1:0] rst_stage_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
    int         loss_exp = 0;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (P),
        .LOCK_STABLE_CYCLES (L),
        .LOCK_TIMEOUT_CYCLES(T),
        .MAX_RETRIES        (R),
        .STAGE_GAP_CYCLES   (G)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .soft_reset_req(soft_reset_req),
        .clear_fault   (clear_fault),
        .pll_rst       (pll_rst),
        .rst_stage_n   (rst_stage_n),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample and drive 1 ns after the rising edge
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic logic cur(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return rst_stage_n[0];
            2:       return ready;
            3:       return fault;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles until the selected output takes value val; -1 if the budget runs out
    task automatic wait_sig(input int sel, input logic val, output int n);
        n = 0;
        while (cur(sel) != val && n < BUDGET) begin
            tick();
            n++;
        end
        if (cur(sel) != val) n = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_stage"}, int'(rst_stage_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    // From WAIT_LOCK entry with the pin low: raise lock after d cycles and
    // expect stage 0 L+3 cycles later, then stage 1 and ready G cycles after that
    task automatic run_lock(input int d, input string tag);
        int n;
        repeat (d) tick();
        pll_locked = 1'b1;
        wait_sig(1, 1'b1, n);
        chk({tag, "_stage0_lat"}, n, L + 3);
        chk({tag, "_stage01"}, int'(rst_stage_n), 1);
        chk({tag, "_ready_early"}, int'(ready), 0);
        wait_sig(2, 1'b1, n);
        chk({tag, "_ready_lat"}, n, G);
        chk({tag, "_stage11"}, int'(rst_stage_n), 3);
        chk({tag, "_retry_run"}, int'(retry_cnt), 0);
    endtask

    // In RUN: drop lock, expect shutdown 3 cycles later and a fresh P-cycle pulse
    task automatic lose_lock(input string tag);
        int n;
        pll_locked = 1'b0;
        wait_sig(2, 1'b0, n);
        chk({tag, "_loss_lat"}, n, 3);
        chk({tag, "_loss_stage"}, int'(rst_stage_n), 0);
        chk({tag, "_loss_pllrst"}, int'(pll_rst), 1);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        loss_exp++;
        chk({tag, "_loss_cnt"}, int'(lock_loss_cnt), loss_exp);
`endif
        wait_sig(0, 1'b0, n);
        chk({tag, "_pulse"}, n, P);
    endtask

    initial begin
        int n;
        int a;
        rst_n          = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        clear_fault    = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");

        // Nominal lock
        rst_n = 1'b1;
        wait_sig(0, 1'b0, n);
        chk("nom_pulse", n, P);
        run_lock(10, "nom");

        // Loss in RUN, then resequence with a random lock delay
        lose_lock("loss1");
        run_lock(int'($urandom_range(T - 3, 0)), "relock1");

        // Soft reset in RUN, then an ignored one in RESET_PLL
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("soft_pllrst", int'(pll_rst), 1);
        chk("soft_ready", int'(ready), 0);
        chk("soft_stage", int'(rst_stage_n), 0);
        tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        wait_sig(0, 1'b0, n);
        chk("soft_ign_pulse", n + 2, P);
        // Lock still present: one cycle to notice it, then L stable cycles
        wait_sig(1, 1'b1, n);
        chk("soft_stage0_lat", n, L + 1);
        wait_sig(2, 1'b1, n);
        chk("soft_ready_lat", n, G);

        // Lock glitches during STABLE: first at the 8th cycle, then random
        for (int k = 0; k < 2; k++) begin
            lose_lock("gl_loss");
            tick();
            tick();
            pll_locked = 1'b1;
            a = (k == 0) ? 8 : int'($urandom_range(L - 1, 1));
            repeat (a) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            wait_sig(1, 1'b1, n);
            chk("glitch_stage0_lat", n, L + 3);
            chk("glitch_retry", int'(retry_cnt), 0);
            wait_sig(2, 1'b1, n);
            chk("glitch_ready_lat", n, G);
        end

        // Reset asserted while in RELEASE0
        lose_lock("mid_loss");
        pll_locked = 1'b1;
        wait_sig(1, 1'b1, n);
        chk("mid_stage0_lat", n, L + 3);
        tick();
        chk("mid_in_release0", int'(rst_stage_n), 1);
        chk("mid_not_ready", int'(ready), 0);
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
`ifdef PLL_SEQ_LOSS_COUNT_EN
        loss_exp = 0;
        chk("mid_loss_cnt", int'(lock_loss_cnt), loss_exp);
`endif
        rst_n = 1'b1;
        wait_sig(0, 1'b0, n);
        chk("mid_pulse", n, P);

        // Timeouts, retries, then fault
        for (int i = 1; i <= R; i++) begin
            wait_sig(0, 1'b1, n);
            chk("to_wait", n, T);
            chk("to_retry", int'(retry_cnt), i);
            chk("to_no_fault", int'(fault), 0);
            wait_sig(0, 1'b0, n);
            chk("to_pulse", n, P);
        end
        wait_sig(3, 1'b1, n);
        chk("fault_wait", n, T);
        chk("fault_pllrst", int'(pll_rst), 1);
        chk("fault_stage", int'(rst_stage_n), 0);
        chk("fault_retry", int'(retry_cnt), R);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        repeat (int'($urandom_range(8, 1))) tick();
        chk("fault_held", int'(fault), 1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clr_fault", int'(fault), 0);
        chk("clr_retry", int'(retry_cnt), 0);
        chk("clr_pllrst", int'(pll_rst), 1);
        wait_sig(0, 1'b0, n);
        chk("clr_pulse", n, P);

        // Randomized lock delays with loss/relock
        for (int k = 0; k < 4; k++) begin
            run_lock(int'($urandom_range(T - 3, 0)), "rnd");
            lose_lock("rnd");
        end
        run_lock(int'($urandom_range(T - 3, 0)), "final");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Supervises the clock PLL and sequences the reset of the logic it clocks. It runs on the free-running reference clock and drives the PLL reset, then waits for a stable lock. It releases two downstream reset stages in order and recovers automatically on loss of lock. It retries a PLL that does not lock within a bound and latches a fault when the retries are exhausted.

## Interface
- RST_PULSE_CYCLES, 16: width of the PLL reset pulse, in refclk cycles (≥2).
- LOCK_STABLE_CYCLES, 1024: number of consecutive synchronized-locked cycles required before release.
- LOCK_TIMEOUT_CYCLES, 65536: maximum number of cycles to wait for lock after the PLL reset.
- MAX_RETRIES, 3: number of PLL re-reset attempts before a fault.
- STAGE_GAP_CYCLES, 8: delay between the stage-0 release and the stage-1 release.
- refclk  in  1  reference clock, 50 MHz free-running.
- rst_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to refclk; synchronized internally.
- soft_reset_req  in  1  single-cycle request to re-run the full sequence.
- clear_fault  in  1  single-cycle request to leave FAULT.
- pll_rst  out  1  active-high reset to the PLL.
- rst_stage_n  out  2  active-low downstream resets; bit 0 is released first.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  current retry count.

## Operation
- Reset values: pll_rst=1, rst_stage_n=2'b00, ready=0, fault=0, retry_cnt=0. The state after reset is RESET_PLL with the cycle counter at 0.
- All outputs are registered and decoded from the next state.
- The FSM has six states: RESET_PLL, WAIT_LOCK, STABLE, RELEASE0, RUN, FAULT.
- RESET_PLL:
  - pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
  - soft_reset_req is ignored.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - If the counter reaches LOCK_TIMEOUT_CYCLES-1 with no lock: when retry_cnt<MAX_RETRIES, increment retry_cnt and go to RESET_PLL; otherwise go to FAULT.
- STABLE:
  - Count consecutive locked_s=1 cycles. Reaching LOCK_STABLE_CYCLES goes to RELEASE0.
  - Any locked_s=0 returns to WAIT_LOCK. The timeout counter restarts and retry_cnt does not change.
- RELEASE0:
  - rst_stage_n=2'b01.
  - After STAGE_GAP_CYCLES cycles go to RUN.
  - locked_s=0 goes to RESET_PLL.
- RUN:
  - rst_stage_n=2'b11, ready=1, retry_cnt cleared on entry.
  - locked_s=0 goes to RESET_PLL and asserts both stages in the same cycle.
- FAULT:
  - pll_rst=1, rst_stage_n=0, fault=1.
  - Only clear_fault acts: go to RESET_PLL with retry_cnt=0.
- soft_reset_req in WAIT_LOCK, STABLE, RELEASE0 or RUN goes to RESET_PLL without incrementing retry_cnt.
- Priority: rst_n > locked_s loss > soft_reset_req.
- Every state transition clears the cycle counter.
- The counter width is $clog2 of the largest of the four cycle parameters. It never wraps: it holds when it reaches the terminal count.

## Timing
- The pll_locked synchronizer has 2 flops, so locked_s lags the pin by 2 cycles.
- The rst_stage_n[0] rise occurs LOCK_STABLE_CYCLES+3 cycles after pll_locked is first sampled high in WAIT_LOCK.
- rst_stage_n[1] and ready rise STAGE_GAP_CYCLES cycles after rst_stage_n[0].
- Loss of lock in RUN: rst_stage_n=0 and ready=0 appear 3 cycles after pll_locked is sampled low. pll_rst rises in the same cycle.
- Sampled soft_reset_req or clear_fault: outputs change on the next edge (1-cycle latency).
- rst_n low for one edge returns all outputs to their reset values, whatever the current state.

## Configuration
- PLL_SEQ_LOSS_COUNT_EN defined: adds output lock_loss_cnt[7:0].
  - Increments on each loss of lock in RELEASE0 or RUN.
  - Saturates at 255.
  - Cleared only by rst_n.
- PLL_SEQ_LOSS_COUNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package pll_seq_pkg holds the state enum type and the stage-count constant (2).
- One sub-module, pll_lock_sync, is the 2-flop synchronizer for pll_locked. Its flops reset to 0.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2, STAGE_GAP_CYCLES=4.

- Nominal lock:
  - Stimulus: release rst_n; raise pll_locked 10 cycles after pll_rst falls.
  - Required: pll_rst high for exactly 4 cycles; rst_stage_n[0] rises 19 cycles after pll_locked is sampled high; rst_stage_n[1] and ready rise 4 cycles later.
- Lock glitch during STABLE:
  - Stimulus: drop pll_locked for 1 cycle after 8 stable cycles.
  - Required: no release; the stable count restarts; retry_cnt stays 0.
- Timeout and fault:
  - Stimulus: hold pll_locked=0.
  - Required: retry_cnt goes 1, then 2, each time with a 4-cycle pll_rst pulse; after the third timeout, fault=1 and pll_rst=1; clear_fault then gives retry_cnt=0 and a new pulse.
- Loss in RUN:
  - Stimulus: drop pll_locked in RUN.
  - Required: rst_stage_n=0 and ready=0 three cycles later; full resequence on relock; lock_loss_cnt=1 when PLL_SEQ_LOSS_COUNT_EN is defined.
- Soft reset:
  - Stimulus: pulse soft_reset_req in RUN, then again in RESET_PLL.
  - Required: the first pulse restarts the sequence; the second is ignored (pulse width stays 4 cycles).
- Mid-sequence reset:
  - Stimulus: assert rst_n in RELEASE0.
  - Required: the next cycle shows reset values on all outputs.
